// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - block handshake, key-fetch and datapath-control bundle for the AES round sequencer
interface aes_round_ctrl_if #(
  parameter int RND_W = 4
);
  logic             IN_VALID;
  logic             IN_READY;
  logic             MODE_256;
  logic             KEY_REQ;
  logic             KEY_RDY;
  logic [RND_W-1:0] ROUND;
  logic             LOAD_SEL;
  logic             STATE_EN;
  logic             LAST_ROUND;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             BUSY;

  modport master (
    input  IN_VALID, MODE_256, KEY_RDY, OUT_READY,
    output IN_READY, KEY_REQ, ROUND, LOAD_SEL, STATE_EN, LAST_ROUND, OUT_VALID, BUSY
  );

  modport slave (
    output IN_VALID, MODE_256, KEY_RDY, OUT_READY,
    input  IN_READY, KEY_REQ, ROUND, LOAD_SEL, STATE_EN, LAST_ROUND, OUT_VALID, BUSY
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - round sequencer for the iterative AES-128/256 encryption core
module aes_round_ctrl #(
  parameter int STAGE_LAT = 3,
  parameter int RND_W     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  aes_round_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEYWAIT,
    S_RUN,
    S_HOLD
  } state_t;

  state_t           state, state_nx;
  logic [RND_W-1:0] round, round_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             mode, mode_nx;
  logic             armed;
  logic [RND_W-1:0] nr;
  logic             last_stage;

  assign nr         = mode ? RND_W'(14) : RND_W'(10);
  assign last_stage = (cnt == 4'(STAGE_LAT - 1));

  // armed keeps IN_READY low while in reset and raises it on the first edge after release
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      round <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      round <= round_nx;
      cnt   <= cnt_nx;
      mode  <= mode_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    round_nx = round;
    cnt_nx   = cnt;
    mode_nx  = mode;
    case (state)
      S_IDLE: begin
        if (bus.IN_VALID && armed) begin
          mode_nx  = bus.MODE_256;
          round_nx = '0;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        round_nx = RND_W'(1);
        state_nx = S_KEYWAIT;
      end
      S_KEYWAIT: begin
        if (bus.KEY_RDY) begin
          cnt_nx   = '0;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        cnt_nx = cnt + 4'd1;
        if (last_stage) begin
          cnt_nx = '0;
          if (round == nr) begin
            state_nx = S_HOLD;
          end else begin
            round_nx = round + RND_W'(1);
            state_nx = S_KEYWAIT;
          end
        end
      end
      S_HOLD: begin
        if (bus.OUT_READY) begin
          round_nx = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.IN_READY   = armed && (state == S_IDLE);
  assign bus.KEY_REQ    = (state == S_KEYWAIT);
  assign bus.ROUND      = round;
  assign bus.LOAD_SEL   = (state == S_LOAD);
  assign bus.STATE_EN   = (state == S_LOAD) || ((state == S_RUN) && last_stage);
  assign bus.LAST_ROUND = ((state == S_KEYWAIT) || (state == S_RUN)) && (round == nr);
  assign bus.OUT_VALID  = (state == S_HOLD);
  assign bus.BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - randomized timeline-model bench for the AES round sequencer
module tb_aes_round_ctrl;
  localparam int SL = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  aes_round_ctrl_if #(.RND_W(4)) bus ();

  aes_round_ctrl #(.STAGE_LAT(SL), .RND_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  // One expected cycle of a block, plus the inputs the bench drives in that cycle
  typedef struct {
    logic [3:0] rnd;
    bit kreq, sen, last, load, ov, krdy, ordy;
  } exp_t;

  function automatic exp_t mk(input int rnd, input bit kreq, input bit sen, input bit last,
                              input bit load, input bit ov, input bit krdy, input bit ordy);
    exp_t e;
    e.rnd = 4'(rnd); e.kreq = kreq; e.sen = sen; e.last = last;
    e.load = load; e.ov = ov; e.krdy = krdy; e.ordy = ordy;
    return e;
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({bus.ROUND, bus.KEY_REQ, bus.STATE_EN, bus.LAST_ROUND, bus.LOAD_SEL,
                bus.OUT_VALID, bus.BUSY, bus.IN_READY});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bit seen;
    bus.IN_VALID = 1'b0;
    RST = 1'b0;
    #1 chk("abort_outs_zero", obs_vec(), 32'h0);
    @(posedge CLK); #1 chk("abort_outs_held", obs_vec(), 32'h0);
    @(negedge CLK); RST = 1'b1;
    #1 chk("abort_rdy_pre_edge", 32'(bus.IN_READY), 32'h0);
    @(posedge CLK); #1 chk("abort_rdy_post_edge", obs_vec(), 32'h1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (bus.OUT_VALID || bus.BUSY) seen = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen), 32'h0);
  endtask

  // Expands the block into its expected cycle timeline from the round/key/hold schedule
  task automatic run_block(input bit m256, input int kd [15], input int hw, input int abort_idx);
    exp_t tl[$];
    int   nr, lat_exp, first_ov;
    nr = m256 ? 14 : 10;
    lat_exp = 1;
    tl.push_back(mk(0, 0, 1, 0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
    for (int r = 1; r <= nr; r++) begin
      lat_exp += kd[r] + 1 + SL;
      for (int k = 0; k <= kd[r]; k++)
        tl.push_back(mk(r, 1, 0, r == nr, 0, 0, k == kd[r], 1'($urandom_range(0, 1))));
      for (int s = 0; s < SL; s++)
        tl.push_back(mk(r, 0, s == SL - 1, r == nr, 0, 0,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
    end
    for (int k = 0; k <= hw; k++)
      tl.push_back(mk(nr, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), k == hw));

    bus.IN_VALID = 1'b1;
    bus.MODE_256 = m256;
    first_ov = -1;
    foreach (tl[i]) begin
      @(posedge CLK); #1;
      bus.KEY_RDY   = tl[i].krdy;
      bus.OUT_READY = tl[i].ordy;
      bus.IN_VALID  = tl[i].ov ? 1'b1 : 1'($urandom_range(0, 1));
      bus.MODE_256  = 1'($urandom_range(0, 1));
      if (i == abort_idx) begin
        do_reset();
        return;
      end
      @(negedge CLK);
      chk($sformatf("cycle_m%0d_i%0d", nr, i), obs_vec(),
          32'({tl[i].rnd, tl[i].kreq, tl[i].sen, tl[i].last, tl[i].load, tl[i].ov, 1'b1, 1'b0}));
      if (first_ov < 0 && bus.OUT_VALID) first_ov = i;
    end
    chk($sformatf("latency_m%0d", nr), 32'(first_ov), 32'(lat_exp));
    @(posedge CLK); #1;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    @(negedge CLK);
    chk("idle_after_block", obs_vec(), 32'h1);
  endtask

  initial begin
    int kd [15];
    bus.IN_VALID = 1'b0; bus.MODE_256 = 1'b0; bus.KEY_RDY = 1'b0; bus.OUT_READY = 1'b0;
    kd = '{default: 0};

    repeat (2) @(posedge CLK);
    #1 chk("reset_outs_zero", obs_vec(), 32'h0);
    @(negedge CLK); RST = 1'b1;
    #1 chk("reset_rdy_pre_edge", 32'(bus.IN_READY), 32'h0);
    @(posedge CLK); #1 chk("reset_rdy_post_edge", obs_vec(), 32'h1);

    run_block(1'b0, kd, 0, -1);
    run_block(1'b1, kd, 0, -1);
    kd[4] = 5;
    run_block(1'b0, kd, 0, -1);
    kd[4] = 0;
    run_block(1'b1, kd, 7, -1);
    run_block(1'b0, kd, 7, -1);
    run_block(1'b0, kd, 0, 22);
    run_block(1'b1, kd, 2, -1);

    for (int b = 0; b < 8; b++) begin
      for (int r = 1; r <= 14; r++) kd[r] = int'($urandom_range(0, 3));
      run_block(1'($urandom_range(0, 1)), kd, int'($urandom_range(0, 4)), -1);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
